// File: rtl/hdmi_packet_pkg.sv
// Shared definitions for the HDMI data island packet serializer.
// Holds the BCH(64,56)/(32,24) generator constant, the packet geometry,
// the subpacket array type, the serializer FSM state type, and the one-bit
// BCH step used by every ECC register.
package hdmi_packet_pkg;

    // x^8 + x^7 + x^6 + 1, applied in a right-shifting register.
    localparam logic [7:0]  BCH_POLY       = 8'h83;
    localparam int unsigned PKT_SLICES     = 32;
    localparam int unsigned HDR_DATA_BITS  = 24;
    localparam int unsigned SUB_DATA_PAIRS = 28;
    localparam int unsigned NUM_SUBS       = 4;
    localparam int unsigned SUB_BITS       = 56;

    // Subpackets 0..3, each 7 bytes with byte 0 in bits 7:0.
    typedef logic [NUM_SUBS-1:0][SUB_BITS-1:0] sub_array_t;

    typedef enum logic {
        StIdle,
        StSend
    } ser_state_e;

    // Fold one data bit into the running ECC.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic d);
        logic fb;
        fb = ecc[0] ^ d;
        return (ecc >> 1) ^ (fb ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bch_ecc_lfsr.sv
// Eight-bit BCH parity register for one data island ECC block.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset, clears the parity
//   clr_i     synchronous clear (start of a new packet), wins over en_i
//   en_i      fold this cycle's data bit(s) into the parity
//   d0_i      first data bit of the cycle
//   d1_i      second data bit of the cycle (used only when TwoBit=1)
//   ecc_o     current parity value
module bch_ecc_lfsr
    import hdmi_packet_pkg::*;
#(
    // 0: one bit per cycle (header); 1: d0_i then d1_i per cycle (subpackets)
    parameter logic TwoBit = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       d0_i,
    input  logic       d1_i,
    output logic [7:0] ecc_o
);

    logic [7:0] ecc_q, ecc_d;
    logic [7:0] step_one;
    logic [7:0] step_two;

    always_comb begin
        step_one = bch_step(ecc_q, d0_i);
        step_two = bch_step(step_one, d1_i);
        ecc_d    = ecc_q;
        if (clr_i) begin
            ecc_d = '0;
        end else if (en_i) begin
            ecc_d = TwoBit ? step_two : step_one;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ecc_q <= '0;
        end else begin
            ecc_q <= ecc_d;
        end
    end

    assign ecc_o = ecc_q;

endmodule

// File: rtl/data_island_packet_serializer.sv
// HDMI data island packet serializer.
// Accepts a 24-bit header plus four 56-bit subpackets and emits them as 32
// nine-bit slices, appending the BCH parity of the header (slices 24..31)
// and of each subpacket (slices 28..31). The packet is latched on
// acceptance, so the inputs may change freely while it is sent.
// Ports:
//   clk_pixel    pixel clock, all state changes on its rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     a packet is presented on header/sub
//   in_ready     a packet can be accepted this cycle
//   header       HB2..HB0, HB0 in bits 7:0
//   sub          subpackets 3..0, 56 bits each
//   out_valid    packet_data carries a slice
//   packet_data  bit 0 header/ECC, bits 4:1 even bits of sub 3..0,
//                bits 8:5 odd bits of sub 3..0
//   packet_last  high with the 32nd slice
module data_island_packet_serializer
    import hdmi_packet_pkg::*;
#(
    // Allow the next packet to be taken during the last slice of the current one.
    parameter logic BACK_TO_BACK = 1'b1
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic             out_valid,
    output logic [8:0]       packet_data,
    output logic             packet_last
);

    localparam logic [4:0] LastCnt = 5'(PKT_SLICES - 1);
    localparam logic [4:0] HdrEnd  = 5'(HDR_DATA_BITS);
    localparam logic [4:0] SubEnd  = 5'(SUB_DATA_PAIRS);

    ser_state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [23:0] hdr_q, hdr_d;
    sub_array_t sub_q, sub_d;

    logic at_last;
    logic accept;
    logic clr_ecc;
    logic in_hdr_data;
    logic in_sub_data;
    logic hdr_en;
    logic sub_en;
    logic hdr_bit;
    logic [NUM_SUBS-1:0] sub_even;
    logic [NUM_SUBS-1:0] sub_odd;
    logic [7:0] hdr_ecc;
    logic [7:0] sub_ecc [NUM_SUBS];

    assign at_last     = (state_q == StSend) && (cnt_q == LastCnt);
    assign in_ready    = (state_q == StIdle) || (at_last && BACK_TO_BACK);
    assign accept      = in_valid && in_ready;
    assign in_hdr_data = cnt_q < HdrEnd;
    assign in_sub_data = cnt_q < SubEnd;
    assign hdr_en      = (state_q == StSend) && in_hdr_data;
    assign sub_en      = (state_q == StSend) && in_sub_data;

    // Data bits of the current slice; only meaningful while in the data
    // region, the ECC enables and the output mux ignore them elsewhere.
    always_comb begin
        hdr_bit = hdr_q[cnt_q];
        for (int unsigned k = 0; k < NUM_SUBS; k++) begin
            sub_even[k] = sub_q[k][{cnt_q, 1'b0}];
            sub_odd[k]  = sub_q[k][{cnt_q, 1'b1}];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        sub_d   = sub_q;
        clr_ecc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StSend;
                    cnt_d   = '0;
                    hdr_d   = header;
                    sub_d   = sub;
                    clr_ecc = 1'b1;
                end
            end
            StSend: begin
                if (!at_last) begin
                    cnt_d = cnt_q + 5'd1;
                end else if (accept) begin
                    // Gapless hand-over to the next packet.
                    cnt_d   = '0;
                    hdr_d   = header;
                    sub_d   = sub;
                    clr_ecc = 1'b1;
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hdr_q   <= '0;
            sub_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            sub_q   <= sub_d;
        end
    end

    bch_ecc_lfsr #(
        .TwoBit(1'b0)
    ) u_hdr_ecc (
        .clk_i (clk_pixel),
        .rst_ni(reset_n),
        .clr_i (clr_ecc),
        .en_i  (hdr_en),
        .d0_i  (hdr_bit),
        .d1_i  (1'b0),
        .ecc_o (hdr_ecc)
    );

    for (genvar k = 0; k < NUM_SUBS; k++) begin : g_sub_ecc
        bch_ecc_lfsr #(
            .TwoBit(1'b1)
        ) u_sub_ecc (
            .clk_i (clk_pixel),
            .rst_ni(reset_n),
            .clr_i (clr_ecc),
            .en_i  (sub_en),
            .d0_i  (sub_even[k]),
            .d1_i  (sub_odd[k]),
            .ecc_o (sub_ecc[k])
        );
    end

    // Outputs depend only on registered state, never on the inputs.
    always_comb begin
        out_valid   = 1'b0;
        packet_last = 1'b0;
        packet_data = '0;
        if (state_q == StSend) begin
            out_valid   = 1'b1;
            packet_last = at_last;
            // Slices 24..31 carry parity bits 0..7; cnt_q[2:0] is that offset.
            packet_data[0] = in_hdr_data ? hdr_bit : hdr_ecc[cnt_q[2:0]];
            for (int unsigned k = 0; k < NUM_SUBS; k++) begin
                if (in_sub_data) begin
                    packet_data[1 + k] = sub_even[k];
                    packet_data[5 + k] = sub_odd[k];
                end else begin
                    packet_data[1 + k] = sub_ecc[k][{cnt_q[1:0], 1'b0}];
                    packet_data[5 + k] = sub_ecc[k][{cnt_q[1:0], 1'b1}];
                end
            end
        end
    end

endmodule

// File: doc/data_island_packet_serializer.md
DATA_ISLAND_PACKET_SERIALIZER -- requirements
Module: data_island_packet_serializer

Interface
REQ-001 Parameter: BACK_TO_BACK, default 1'b1; when 1, a new packet may be accepted in the final cycle of the current packet.
REQ-002 Port: clk_pixel  input  1  pixel clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  a packet is presented on header/sub.
REQ-005 Port: in_ready  output  1  the serializer can accept a packet this cycle.
REQ-006 Port: header  input  24  packet header bytes HB2..HB0, with HB0 in bits 7:0.
REQ-007 Port: sub  input  4x56  subpackets 0..3, each holding 7 bytes with byte 0 in bits 7:0.
REQ-008 Port: out_valid  output  1  packet_data carries a packet bit-slice.
REQ-009 Port: packet_data  output  9  per-cycle slice: bit 0 = header/ECC bit; bits 4:1 = even bits of subpackets 3..0; bits 8:5 = odd bits of subpackets 3..0.
REQ-010 Port: packet_last  output  1  high with the 32nd slice of a packet.

Function
REQ-011 States SHALL be IDLE and SEND; cnt[4:0] SHALL index the slice within a packet.
REQ-012 IDLE: in_ready=1, out_valid=0, packet_data=0.
REQ-013 IDLE with in_valid=1: on the next edge, latch header and sub, clear all ECC registers, set cnt=0, enter SEND.
REQ-014 SEND: out_valid=1; all outputs driven only from registers; first slice appears the cycle after acceptance.
REQ-015 Header bit: cnt 0..23 -> header[cnt]; cnt 24..31 -> hdr_ecc[cnt-24].
REQ-016 Subpacket k, cnt 0..27: even output = sub[k][2*cnt], odd output = sub[k][2*cnt+1].
REQ-017 Subpacket k, cnt 28..31: even output = ecc_k[2*(cnt-28)], odd output = ecc_k[2*(cnt-28)+1].
REQ-018 ECC step (BCH, polynomial x^8+x^7+x^6+1): fb = ecc[0] XOR d; ecc_next = (ecc >> 1) XOR (fb ? 8'h83 : 8'h00).
REQ-019 The header ECC SHALL step once per cycle over cnt 0..23; each subpacket ECC SHALL step twice per cycle (even bit, then odd bit) over cnt 0..27; ECC registers SHALL hold during ECC transmission.
REQ-020 packet_last SHALL equal (state==SEND && cnt==31).
REQ-021 At cnt==31: if BACK_TO_BACK=1, in_ready=1, and in_valid=1, the block SHALL accept the next packet without a gap (cnt wraps to 0, ECC cleared); otherwise it SHALL return to IDLE.
REQ-022 in_ready SHALL be 0 in SEND for cnt 0..30, and the latched header/sub SHALL be immune to input changes.
REQ-023 cnt SHALL wrap 31->0 only on back-to-back acceptance and never exceed 31.

Reset
REQ-024 reset_n low SHALL immediately force IDLE, cnt=0, all ECC and latched data registers to 0, out_valid=0, packet_data=0, packet_last=0, and in_ready=1 (while asserted and after release).
REQ-025 Reset mid-packet SHALL abandon the packet; no partial slice SHALL follow reset release.

Structure
REQ-026 Package hdmi_packet_pkg SHALL hold BCH_POLY=8'h83, PKT_SLICES=32, HDR_DATA_BITS=24, SUB_DATA_PAIRS=28, and the sub-array typedef.
REQ-027 Sub-module bch_ecc_lfsr (one/two-bit step, clear, enable) SHALL be instantiated five times: one for the header, one per subpacket.

Verification
REQ-028 All-zero header/sub -> 32 slices of packet_data=0, packet_last on slice 32 only.
REQ-029 header=24'h000001, sub=0 -> bit 0 = 1 at slice 0, 0 at slices 1..23, then 8'h4A LSB-first over slices 24..31.
REQ-030 sub[0]=56'h1, others 0 -> packet_data[1]=1 at slice 0, all others 0 until slice 28; ECC bits at slices 28..31 match the golden REQ-018 model.
REQ-031 in_valid held high with BACK_TO_BACK=1 -> two packets in 64 consecutive out_valid cycles; with BACK_TO_BACK=0 -> exactly one idle cycle between packets.
REQ-032 reset_n pulsed low at slice 10 -> outputs 0 at once; next accepted packet is bit-exact with the golden model.
REQ-033 header/sub toggled randomly during SEND -> transmitted packet equals the values latched at acceptance.
